// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and constants for the FIFO-draining serial transmitter.
// The optional parity state is enabled in the top by FIFO_SERIAL_TX_PARITY_EN.
package fifo_serial_pkg;

    localparam int DEF_DATA_W       = 16;
    localparam int DEF_CLKS_PER_BIT = 4;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } txState_t;

endpackage

// File: rtl/fifo_serial_tx_if.sv
// Read-port bundle between the synchronous FIFO and its serial consumer.
// The consumer side is the master because it drives the read strobe.
interface fifo_serial_tx_if
    import fifo_serial_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic              fifo_read;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;

    modport master (output fifo_read, input fifo_empty, input fifo_data);
    modport slave  (input fifo_read, output fifo_empty, output fifo_data);

endinterface

// File: rtl/fifo_serial_tx_serial_bit_timer.sv
// Free-running baud counter: counts 0..CLKS_PER_BIT-1, ticks on the terminal count.
// o_preTick flags the cycle just before a tick so callers can register end-of-bit pulses.
module serial_bit_timer
    import fifo_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    output logic o_tick,
    output logic o_preTick
);

    localparam int            CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE   = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tick    = (r_count == LAST);
    assign o_preTick = (r_count == PRE);

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from the FIFO read port and sends them LSB-first as start/data/stop frames.
// Define FIFO_SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_serial_tx
    import fifo_serial_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_enable,
    fifo_serial_tx_if.master  fifoBus,
    output logic              o_tx_out,
    output logic              o_busy,
    output logic              o_word_done
);

    localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    txState_t          r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [IDX_W-1:0]  r_bitIdx;
    logic              r_fifoRead;
    logic              r_txOut;
    logic              r_busy;
    logic              r_wordDone;
    logic              w_tick;
    logic              w_preTick;
    logic              w_clear;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    logic              r_parity;
`endif

    // The baud counter restarts in LOAD so the start bit gets a full bit period.
    assign w_clear = (r_state == LOAD);

    serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bitTimer (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_clear),
        .o_tick    (w_tick),
        .o_preTick (w_preTick)
    );

    // Outputs are updated on the same edge as the state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bitIdx   <= '0;
            r_fifoRead <= 1'b0;
            r_txOut    <= IDLE_LVL;
            r_busy     <= 1'b0;
            r_wordDone <= 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_fifoRead <= 1'b0;
            r_wordDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_enable && !fifoBus.fifo_empty) begin
                        r_state    <= REQ;
                        r_fifoRead <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                REQ: begin
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_shreg  <= fifoBus.fifo_data;
                    r_bitIdx <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                    r_parity <= ^fifoBus.fifo_data;
`endif
                    r_txOut  <= START_LVL;
                    r_state  <= START;
                end
                START: begin
                    if (w_tick) begin
                        r_txOut <= r_shreg[0];
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shreg <= r_shreg >> 1;
                        if (r_bitIdx == LAST_IDX) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
                            r_txOut <= r_parity;
                            r_state <= PARITY;
`else
                            r_txOut <= STOP_LVL;
                            r_state <= STOP;
`endif
                        end else begin
                            r_bitIdx <= r_bitIdx + 1'b1;
                            r_txOut  <= r_shreg[1];
                        end
                    end
                end
`ifdef FIFO_SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_txOut <= STOP_LVL;
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_preTick) begin
                        r_wordDone <= 1'b1;
                    end
                    if (w_tick) begin
                        r_txOut <= IDLE_LVL;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_txOut <= IDLE_LVL;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign fifoBus.fifo_read = r_fifoRead;
    assign o_tx_out          = r_txOut;
    assign o_busy            = r_busy;
    assign o_word_done       = r_wordDone;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Self-checking bench for fifo_serial_tx: a queue-backed FIFO model feeds the DUT and
// the logged serial line is compared against frames built from each word's bits.
module tb_fifo_serial_tx;
    import fifo_serial_pkg::*;

    localparam int DW  = 16;
    localparam int CPB = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif
    localparam int FRAME = NBITS * CPB;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic enable = 1'b0;
    logic txOut, busy, wordDone;

    fifo_serial_tx_if #(.DATA_W(DW)) fifoBus ();

    fifo_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clock       (clock),
        .reset       (reset),
        .i_enable    (enable),
        .fifoBus     (fifoBus),
        .o_tx_out    (txOut),
        .o_busy      (busy),
        .o_word_done (wordDone)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] fifoMem [0:255];
    int pushCount  = 0;
    int popCount   = 0;
    int underflows = 0;
    int assertions = 0;
    int failures   = 0;

    logic logTx[$];
    logic logBusy[$];
    logic logRead[$];
    logic logDone[$];

    // FIFO model: registered output, data valid the cycle after read is sampled
    assign fifoBus.fifo_empty = (pushCount == popCount);

    always @(posedge clock) begin
        if (fifoBus.fifo_read === 1'b1) begin
            if (pushCount == popCount) begin
                underflows <= underflows + 1;
            end else begin
                fifoBus.fifo_data <= fifoMem[popCount % 256];
                popCount          <= popCount + 1;
            end
        end
    end

    always @(negedge clock) begin
        logTx.push_back(txOut);
        logBusy.push_back(busy);
        logRead.push_back(fifoBus.fifo_read);
        logDone.push_back(wordDone);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pushWord(input logic [DW-1:0] w);
        fifoMem[pushCount % 256] = w;
        pushCount = pushCount + 1;
    endtask

    // Line level expected at a given cycle offset from the start-bit edge
    function automatic logic expLevel(input logic [DW-1:0] w, input int off);
        int b;
        b = off / CPB;
        if (b == 0) return 1'b0;
        if (b <= DW) return w[b-1];
`ifdef FIFO_SERIAL_TX_PARITY_EN
        if (b == DW + 1) return ^w;
`endif
        return 1'b1;
    endfunction

    function automatic int firstBadOffset(input logic [DW-1:0] w, input int s);
        for (int k = 0; k < FRAME; k++) begin
            if (logTx[s+k] !== expLevel(w, k)) return k;
        end
        return -1;
    endfunction

    function automatic int nextRead(input int from);
        for (int i = from; i < logRead.size(); i++) begin
            if (logRead[i] === 1'b1) return i;
        end
        return -1;
    endfunction

    function automatic int countReads(input int from, input int to);
        int c = 0;
        for (int i = from; i < to; i++) if (logRead[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int countDones(input int from, input int to);
        int c = 0;
        for (int i = from; i < to; i++) if (logDone[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic test_reset();
        int start, bad;
        reset = 1'b1;
        enable = 1'b1;
        cycles(3);
        assertions++; if (txOut !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx actual=%b required=1", txOut); end
        assertions++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy actual=%b required=0", busy); end
        assertions++; if (fifoBus.fifo_read !== 1'b0) begin failures++; $display("[TB] FAIL reset_read actual=%b required=0", fifoBus.fifo_read); end
        assertions++; if (wordDone !== 1'b0) begin failures++; $display("[TB] FAIL reset_done actual=%b required=0", wordDone); end
        reset = 1'b0;
        start = logTx.size();
        cycles(200);
        bad = 0;
        for (int i = start; i < logTx.size(); i++) begin
            if (logTx[i] !== 1'b1 || logBusy[i] !== 1'b0 || logRead[i] !== 1'b0) bad++;
        end
        assertions++; if (bad !== 0) begin failures++; $display("[TB] FAIL empty_idle bad_cycles actual=%0d required=0", bad); end
    endtask

    task automatic test_single_word();
        int base, r, s, bad;
        base = logRead.size();
        pushWord(16'hA5C3);
        cycles(FRAME + 20);
        r = nextRead(base);
        assertions++;
        if (r < 0) begin failures++; $display("[TB] FAIL single_read actual=none required=pulse"); return; end
        s = r + 2;
        assertions++; if (countReads(base, logRead.size()) !== 1) begin failures++; $display("[TB] FAIL single_read_count actual=%0d required=1", countReads(base, logRead.size())); end
        assertions++; if (logTx[r+1] !== 1'b1 || logTx[r+2] !== 1'b0) begin failures++; $display("[TB] FAIL start_latency actual=%b%b required=10", logTx[r+1], logTx[r+2]); end
        bad = firstBadOffset(16'hA5C3, s);
        assertions++; if (bad !== -1) begin failures++; $display("[TB] FAIL single_frame bad_offset actual=%0d required=-1", bad); end
        assertions++; if (logDone[s+FRAME-1] !== 1'b1 || countDones(base, logDone.size()) !== 1) begin failures++; $display("[TB] FAIL single_done actual=%b/%0d required=1/1", logDone[s+FRAME-1], countDones(base, logDone.size())); end
        bad = 0;
        for (int i = r; i < s + FRAME; i++) if (logBusy[i] !== 1'b1) bad++;
        if (logBusy[r-1] !== 1'b0) bad++;
        if (logBusy[s+FRAME] !== 1'b0) bad++;
        assertions++; if (bad !== 0) begin failures++; $display("[TB] FAIL single_busy bad_cycles actual=%0d required=0", bad); end
    endtask

    task automatic test_stream(input logic [DW-1:0] words [6], input int n, input string tag);
        int base, r, s, prevS, bad;
        base = logRead.size();
        for (int i = 0; i < n; i++) pushWord(words[i]);
        cycles(n * (FRAME + 3) + 30);
        assertions++; if (countReads(base, logRead.size()) !== n) begin failures++; $display("[TB] FAIL %s_reads actual=%0d required=%0d", tag, countReads(base, logRead.size()), n); end
        assertions++; if (countDones(base, logDone.size()) !== n) begin failures++; $display("[TB] FAIL %s_dones actual=%0d required=%0d", tag, countDones(base, logDone.size()), n); end
        r = base;
        prevS = -1;
        for (int i = 0; i < n; i++) begin
            r = nextRead(r);
            if (r < 0) break;
            s = r + 2;
            bad = firstBadOffset(words[i], s);
            assertions++; if (bad !== -1) begin failures++; $display("[TB] FAIL %s_frame%0d bad_offset actual=%0d required=-1", tag, i, bad); end
            if (i > 0) begin
                assertions++; if (s - prevS !== FRAME + 3) begin failures++; $display("[TB] FAIL %s_spacing%0d actual=%0d required=%0d", tag, i, s - prevS, FRAME + 3); end
            end
            prevS = s;
            r = r + 1;
        end
        assertions++; if (pushCount !== popCount) begin failures++; $display("[TB] FAIL %s_fifo_left actual=%0d required=0", tag, pushCount - popCount); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] words [6];
        words = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        test_stream(words, 3, "b2b");
    endtask

    task automatic test_random_stream();
        logic [DW-1:0] words [6];
        int n;
        for (int i = 0; i < 6; i++) words[i] = DW'($urandom);
        n = $urandom_range(3, 6);
        test_stream(words, n, "rand");
    endtask

    task automatic test_enable_drop();
        logic [DW-1:0] w2;
        int base, r, s, r2, bad;
        w2 = DW'($urandom);
        enable = 1'b1;
        base = logRead.size();
        pushWord(16'h1234);
        pushWord(w2);
        r = -1;
        for (int i = 0; i < 20 && r < 0; i++) begin cycles(1); r = nextRead(base); end
        assertions++;
        if (r < 0) begin failures++; $display("[TB] FAIL en_read actual=none required=pulse"); return; end
        s = r + 2;
        while (logTx.size() < s + 6 * CPB) cycles(1);
        enable = 1'b0;
        cycles(FRAME + 100);
        bad = firstBadOffset(16'h1234, s);
        assertions++; if (bad !== -1) begin failures++; $display("[TB] FAIL en_frame1 bad_offset actual=%0d required=-1", bad); end
        assertions++; if (countReads(r + 1, logRead.size()) !== 0) begin failures++; $display("[TB] FAIL en_no_read actual=%0d required=0", countReads(r + 1, logRead.size())); end
        assertions++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL en_busy actual=%b required=0", busy); end
        base = logRead.size();
        enable = 1'b1;
        cycles(FRAME + 20);
        r2 = nextRead(base);
        assertions++;
        if (r2 < 0) begin failures++; $display("[TB] FAIL en_resume actual=none required=pulse"); return; end
        bad = firstBadOffset(w2, r2 + 2);
        assertions++; if (bad !== -1) begin failures++; $display("[TB] FAIL en_frame2 bad_offset actual=%0d required=-1", bad); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] wA, wB;
        int base, r, r2, bad;
        wA = DW'($urandom);
        wB = DW'($urandom);
        enable = 1'b1;
        base = logRead.size();
        pushWord(wA);
        pushWord(wB);
        r = -1;
        for (int i = 0; i < 20 && r < 0; i++) begin cycles(1); r = nextRead(base); end
        assertions++;
        if (r < 0) begin failures++; $display("[TB] FAIL rst_read actual=none required=pulse"); return; end
        while (logTx.size() < r + 2 + 9 * CPB) cycles(1);
        reset = 1'b1;
        cycles(1);
        assertions++; if (txOut !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_tx actual=%b required=1", txOut); end
        assertions++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_busy actual=%b required=0", busy); end
        assertions++; if (wordDone !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_done actual=%b required=0", wordDone); end
        reset = 1'b0;
        base = logRead.size();
        assertions++; if (countDones(r, base) !== 0) begin failures++; $display("[TB] FAIL rst_dropped_done actual=%0d required=0", countDones(r, base)); end
        cycles(FRAME + 20);
        r2 = nextRead(base);
        assertions++;
        if (r2 < 0) begin failures++; $display("[TB] FAIL rst_next_read actual=none required=pulse"); return; end
        bad = firstBadOffset(wB, r2 + 2);
        assertions++; if (bad !== -1) begin failures++; $display("[TB] FAIL rst_next_frame bad_offset actual=%0d required=-1", bad); end
    endtask

`ifdef FIFO_SERIAL_TX_PARITY_EN
    task automatic test_parity();
        logic [DW-1:0] words [2];
        logic          pars  [2];
        int base, r, s;
        words = '{16'h0007, 16'h0003};
        pars  = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            base = logRead.size();
            pushWord(words[i]);
            cycles(FRAME + 20);
            r = nextRead(base);
            assertions++;
            if (r < 0) begin failures++; $display("[TB] FAIL parity%0d_read actual=none required=pulse", i); continue; end
            s = r + 2;
            assertions++; if (logTx[s + (DW + 1) * CPB + 1] !== pars[i]) begin failures++; $display("[TB] FAIL parity%0d_bit actual=%b required=%b", i, logTx[s + (DW + 1) * CPB + 1], pars[i]); end
            assertions++; if (logDone[s + 75] !== 1'b1) begin failures++; $display("[TB] FAIL parity%0d_len actual=%b required=1", i, logDone[s + 75]); end
        end
    endtask
`endif

    initial begin
        $display("[TB] fifo_serial_tx bench starting, frame length %0d cycles", FRAME);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_random_stream();
        test_enable_drop();
        test_reset_mid();
`ifdef FIFO_SERIAL_TX_PARITY_EN
        test_parity();
`endif
        cycles(2);
        assertions++; if (underflows !== 0) begin failures++; $display("[TB] FAIL underflow actual=%0d required=0", underflows); end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/fifo_serial_tx.md
# fifo_serial_tx

Read-side consumer for the 16x16 synchronous FIFO. Pops one word whenever the FIFO is non-empty and enabled, and shifts it out LSB-first on a single asynchronous-style serial line. The line is framed with a start bit, data bits and a stop bit. The block sits between the FIFO's read port (read / fifo_out / fifo_empty) and an off-chip serial pin.

## Interface
- DATA_W, 16, word width; must equal the FIFO width.
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range ≥2.
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  allows new words to be popped; a frame in flight always completes.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_W  FIFO fifo_out; registered by the FIFO, valid the cycle after read is sampled.
- fifo_read  out  1  FIFO read strobe; one-cycle pulse per word.
- tx_out  out  1  serial line; idles high.
- busy  out  1  high whenever state ≠ IDLE.
- word_done  out  1  one-cycle pulse on the last clock of the stop bit.

## Operation
- FSM states: IDLE, REQ, LOAD, START, DATA, [PARITY], STOP.
- IDLE → REQ when enable && !fifo_empty; otherwise remain in IDLE.
- REQ: fifo_read = 1 for exactly this cycle; next state is LOAD unconditionally.
- LOAD: capture fifo_data into the shift register; clear the bit index and baud counter; go to START.
- START: tx_out = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx_out = shreg[0]; on each bit tick, shift right and increment the bit index. After bit DATA_W-1, go to PARITY (if compiled in) or STOP.
- STOP: tx_out = 1 for CLKS_PER_BIT cycles. word_done pulses on the final cycle; then go to IDLE.
- fifo_empty is sampled only in IDLE. fifo_read is never asserted while empty is high, so the block never underflows the FIFO.
- enable deasserted mid-frame: the current frame finishes; the FSM then stays in IDLE.
- Reset mid-frame: at the next edge all state returns to IDLE and tx_out = 1. A word already popped is dropped and not retransmitted.
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps; a tick occurs at the terminal count.
- Bit index: $clog2(DATA_W) bits; wraps at DATA_W-1 only through the state change.

## Timing
- All outputs are registered.
- Reset values: fifo_read 0, tx_out 1, busy 0, word_done 0.
- Start-up latency: fifo_read is high in cycle n. LOAD is in n+1. tx_out falls in n+2.
- Frame length: (DATA_W+2)·CLKS_PER_BIT cycles, i.e. 72 at the defaults; 76 with parity.
- Back-to-back words: after STOP, the sequence IDLE, REQ, LOAD adds 3 extra high cycles. The next start bit begins 3 cycles after word_done.
- busy rises in the cycle after IDLE detects data. It falls in the cycle after word_done.

## Configuration
- FIFO_SERIAL_TX_PARITY_EN defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of all DATA_W bits) for CLKS_PER_BIT cycles.
- Not defined: no PARITY state, and DATA goes directly to STOP.

## Structure
- Package fifo_serial_pkg holds:
  - the state enum type;
  - the default DATA_W and CLKS_PER_BIT constants;
  - the line levels IDLE_LVL=1, START_LVL=0, STOP_LVL=1.
- One sub-module, serial_bit_timer: the baud counter with clear input and tick output, parameterised by CLKS_PER_BIT.

## Test plan
- Reset, FIFO empty, enable=1 → fifo_read stays 0, tx_out stays 1, busy 0 for 200 cycles.
- Single word 16'hA5C3 → one fifo_read pulse; tx_out falls 2 cycles after the pulse. The line shows 0, then 1100001110100101 LSB-first, then 1, at 4 clocks/bit. word_done comes 72 cycles after the start-bit edge.
- Three words 16'h0001, 16'h8000, 16'hFFFF queued → exactly 3 fifo_read pulses. Start bits are spaced 75 cycles apart, all bits are correct, and the FIFO ends empty.
- enable dropped at bit 5 of word 16'h1234, with a second word queued → the first frame completes. There is no further fifo_read until enable returns, and then the second frame follows.
- Reset asserted at bit 8 → the next cycle has tx_out=1, busy=0, word_done=0. After release, the next queued word is transmitted from its start bit.
- With FIFO_SERIAL_TX_PARITY_EN and 16'h0007 → parity bit 1 before the stop bit, and a 76-cycle frame. With 16'h0003 → parity bit 0.
